// File: rtl/updown_mod_counter.sv
// Modulo-MODULUS up/down counter with synchronous clear/load, wrap or
// saturate mode, cascade outputs (O_Carry, Sat_hit) and a sticky overflow.
// Optional macro GRAY_OUT_EN adds a registered Gray-coded copy of the count
// (Out_gray); it is only meaningful when MODULUS == 2**WIDTH.
module updown_mod_counter #(
    parameter int unsigned WIDTH   = 5,
    parameter int unsigned MODULUS = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Clr,
    input  logic             Load,
    input  logic [WIDTH-1:0] Load_val,
    input  logic             E,
    input  logic             D,
    input  logic             Sat,
`ifdef GRAY_OUT_EN
    output logic [WIDTH-1:0] Out_gray,
`endif
    output logic [WIDTH-1:0] Out,
    output logic             O_Carry,
    output logic             Sat_hit,
    output logic             Ovf
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   ModExt = (WIDTH + 1)'(MODULUS);

    if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_param
        $error("updown_mod_counter: illegal WIDTH/MODULUS combination");
    end

`ifdef GRAY_OUT_EN
    if (MODULUS != (2 ** WIDTH)) begin : g_bad_gray
        $error("updown_mod_counter: Gray output requires MODULUS == 2**WIDTH");
    end
`endif

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   step_val;
    logic             at_limit;
    logic             count_req;

    // One-step neighbour, one bit wider so a borrow or a step past the top is visible.
    always_comb begin
        step_val = D ? ({1'b0, count_q} - (WIDTH + 1)'(1))
                     : ({1'b0, count_q} + (WIDTH + 1)'(1));
        // Down: borrow out of zero. Up: stepping onto MODULUS (legal counts only).
        at_limit  = D ? step_val[WIDTH] : (step_val >= ModExt);
        count_req = E && !Clr && !Load;
        O_Carry   = count_req && !Sat && at_limit;
        Sat_hit   = count_req && Sat && at_limit;
    end

    // Next-state selection in priority order: clear, load, count, hold.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (Clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (Load) begin
            count_d = (Load_val > MaxVal) ? MaxVal : Load_val;
        end else if (E) begin
            if (!at_limit) begin
                count_d = step_val[WIDTH-1:0];
            end else if (!Sat) begin
                count_d = D ? MaxVal : '0;
                ovf_d   = 1'b1;
            end
        end
    end

    // Count and sticky overflow registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef GRAY_OUT_EN
    logic [WIDTH-1:0] gray_q;

    // Gray copy registered from the next count so it tracks Out on the same edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            gray_q <= '0;
        end else begin
            gray_q <= count_d ^ (count_d >> 1);
        end
    end

    assign Out_gray = gray_q;
`endif

    assign Out = count_q;
    assign Ovf = ovf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter: a driver issues stimulus and pushes
// the model's expected response; a monitor pops and compares each cycle.
module tb_updown_mod_counter;

    localparam int W  = 5;
    localparam int MA = 32;
`ifdef GRAY_OUT_EN
    localparam int MB = 32;
`else
    localparam int MB = 10;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         e = 1'b0;
    logic         d = 1'b0;
    logic         sat = 1'b0;

    logic [W-1:0] out_a, out_b;
    logic         car_a, car_b, sh_a, sh_b, ovf_a, ovf_b;
`ifdef GRAY_OUT_EN
    logic [W-1:0] gray_a, gray_b;
`endif

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(W), .MODULUS(MA)) dut_a (
        .Clk(clk), .Rst(rst), .Clr(clr), .Load(load), .Load_val(load_val),
        .E(e), .D(d), .Sat(sat),
`ifdef GRAY_OUT_EN
        .Out_gray(gray_a),
`endif
        .Out(out_a), .O_Carry(car_a), .Sat_hit(sh_a), .Ovf(ovf_a)
    );

    updown_mod_counter #(.WIDTH(W), .MODULUS(MB)) dut_b (
        .Clk(clk), .Rst(rst), .Clr(clr), .Load(load), .Load_val(load_val),
        .E(e), .D(d), .Sat(sat),
`ifdef GRAY_OUT_EN
        .Out_gray(gray_b),
`endif
        .Out(out_b), .O_Carry(car_b), .Sat_hit(sh_b), .Ovf(ovf_b)
    );

    typedef struct {
        int car_a; int sh_a; int out_a; int ovf_a;
        int car_b; int sh_b; int out_b; int ovf_b;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_a = 0, o_a = 0, m_b = 0, o_b = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: integer arithmetic on the count range 0..modn-1.
    task automatic model(input int modn, input int m, input int o,
                         input int c, input int l, input int v,
                         input int en, input int dir, input int s,
                         output int nm, output int no, output int car, output int sh);
        int raw;
        bit beyond;
        raw    = dir ? m - 1 : m + 1;
        beyond = (raw < 0) || (raw >= modn);
        car    = (en && !c && !l && !s && beyond) ? 1 : 0;
        sh     = (en && !c && !l && s && beyond) ? 1 : 0;
        nm     = m;
        no     = o;
        if (c) begin
            nm = 0;
            no = 0;
        end else if (l) begin
            nm = (v > modn - 1) ? modn - 1 : v;
        end else if (en) begin
            if (!beyond) nm = raw;
            else if (!s) begin
                nm = (raw + modn) % modn;
                no = 1;
            end
        end
    endtask

    task automatic step(input bit c, input bit l, input int v,
                        input bit en, input bit dir, input bit s);
        exp_t x;
        int   nm, no;
        @(posedge clk);
        #2;
        clr = c; load = l; load_val = W'(v); e = en; d = dir; sat = s;
        model(MA, m_a, o_a, c, l, v, en, dir, s, nm, no, x.car_a, x.sh_a);
        m_a = nm; o_a = no; x.out_a = nm; x.ovf_a = no;
        model(MB, m_b, o_b, c, l, v, en, dir, s, nm, no, x.car_b, x.sh_b);
        m_b = nm; o_b = no; x.out_b = nm; x.ovf_b = no;
        q.push_back(x);
    endtask

    // Monitor: combinational outputs before the edge, registers just after it.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q[0];
                chk("carry_a", int'(car_a), x.car_a);
                chk("sathit_a", int'(sh_a), x.sh_a);
                chk("carry_b", int'(car_b), x.car_b);
                chk("sathit_b", int'(sh_b), x.sh_b);
                @(posedge clk);
                #1;
                chk("out_a", int'(out_a), x.out_a);
                chk("ovf_a", int'(ovf_a), x.ovf_a);
                chk("out_b", int'(out_b), x.out_b);
                chk("ovf_b", int'(ovf_b), x.ovf_b);
`ifdef GRAY_OUT_EN
                chk("gray_a", int'(gray_a), x.out_a ^ (x.out_a >> 1));
`endif
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset asserted from time zero, held across an edge with E=1.
        e = 1'b1;
        #1;
        chk("rst_out_a", int'(out_a), 0);
        chk("rst_ovf_a", int'(ovf_a), 0);
        chk("rst_out_b", int'(out_b), 0);
        @(posedge clk);
        #2;
        chk("rst_hold_a", int'(out_a), 0);
        @(negedge clk);
        rst = 1'b0;
        e   = 1'b0;

        // Wrap up through 31 -> 0 (Ovf set), then down 0 -> 31.
        step(0, 1, 30, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        // MODULUS=10 wrap and load clamp.
        step(0, 1, 8, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 25, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        // Saturation at both limits.
        step(0, 1, 31, 0, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        step(0, 1, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1, 1);
        // Priority: clear over load over count, then hold.
        step(1, 1, 7, 1, 0, 0);
        step(0, 1, 7, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1);

        // Asynchronous reset mid-count at 13.
        step(0, 1, 13, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("pre_rst_a", int'(out_a), 13);
        rst = 1'b1;
        #1;
        chk("async_rst_out_a", int'(out_a), 0);
        chk("async_rst_ovf_a", int'(ovf_a), 0);
        chk("async_rst_out_b", int'(out_b), 0);
        m_a = 0; o_a = 0; m_b = 0; o_b = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step(0, 0, 0, 1, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 31), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end

        // Full up-count through the wrap (exercises Gray when enabled).
        step(1, 0, 0, 0, 0, 0);
        repeat (34) step(0, 0, 0, 1, 0, 0);

        @(posedge clk);
        @(posedge clk);
        #3;
        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
Parametrised modulo-N up/down counter with synchronous load, clear, wrap/saturate mode, carry/borrow output and a sticky overflow flag. It is the next generation of the 5-bit FIFO pointer/occupancy counter. FIFO control logic uses it for read/write pointers (wrap mode) and occupancy counts (saturate mode). Optional Gray-coded output serves clock-domain crossing of pointers.

Parameters:
WIDTH, 5, counter width in bits; legal range 2..16.
MODULUS, 32, count range 0..MODULUS-1; legal 2 <= MODULUS <= 2**WIDTH.

Ports:
Clk  input  1  clock, rising edge.
Rst  input  1  asynchronous active-high reset.
Clr  input  1  synchronous clear to 0.
Load  input  1  synchronous load of Load_val.
Load_val  input  WIDTH  value to load.
E  input  1  count enable.
D  input  1  direction; 0 = up, 1 = down.
Sat  input  1  mode; 0 = wrap, 1 = saturate.
Out  output  WIDTH  registered count.
O_Carry  output  1  combinational; 1 when E=1, Sat=0, no Clr/Load, and the next edge wraps (up at MODULUS-1 or down at 0).
Sat_hit  output  1  combinational; 1 when E=1, Sat=1, no Clr/Load, and the count is held at a limit (up at MODULUS-1 or down at 0).
Ovf  output  1  registered sticky flag; set on any wrap event.

Behaviour:
- Reset: Rst=1 asynchronously forces Out=0 and Ovf=0 (and Out_gray=0 when enabled). The count is held while Rst=1. The first update occurs on the first rising edge after deassertion.
- Priority per rising edge: Rst > Clr > Load > E count > hold.
- Clr=1:
  - Out<=0, Ovf<=0.
  - Load and E are ignored.
- Load=1 (Clr=0):
  - Out<=Load_val when Load_val <= MODULUS-1; otherwise Out<=MODULUS-1 (clamp).
  - Ovf unchanged; E ignored.
- E=1, D=0, Sat=0: Out<=Out+1. At MODULUS-1, Out<=0 and Ovf<=1.
- E=1, D=1, Sat=0: Out<=Out-1. At 0, Out<=MODULUS-1 and Ovf<=1.
- E=1, Sat=1: counts the same way, but holds at MODULUS-1 going up and at 0 going down. Ovf is unchanged.
- E=0: Out holds.
- Arithmetic:
  - Internal next-value computed WIDTH+1 bits wide.
  - Wrap compares against MODULUS-1, not 2**WIDTH-1, so non-power-of-2 moduli never reach illegal codes.
- Latency: one cycle from an E/Load/Clr edge to Out.
- O_Carry and Sat_hit are purely combinational from the current Out, E, D, Sat, Clr and Load. They are for cascading E into a higher counter stage.
- Mid-operation changes: D or Sat may change on any cycle and take effect at the next edge. There is no pipeline state.
- MODULUS = 2**WIDTH: wrap equals natural binary rollover.

Optional Feature:
Macro GRAY_OUT_EN.
- Defined:
  - Adds output port Out_gray [WIDTH-1:0], a registered value updated on the same edge as Out.
  - Out_gray = bin2gray(next Out); reset value 0.
  - Valid Gray sequence only when MODULUS = 2**WIDTH. Any other MODULUS is a parameter error and is flagged by a simulation-time $error.
- Undefined: the Out_gray port and its register are absent; all other behaviour is identical.

Test Plan:
1. Rst=1 mid-count (Out=13) -> Out=0 and Ovf=0 immediately, without a clock edge; after release with E=1, D=0 -> 1, 2, 3 on successive edges.
2. WIDTH=5, MODULUS=32, Sat=0, D=0, E=1 from 30 -> 31 (O_Carry=1 while Out=31), then 0 with Ovf=1; D=1 from 0 -> 31, Ovf stays 1.
3. MODULUS=10, Sat=0, up from 8 -> 9, 0, 1, never 10..31; Load_val=25 -> Out=9; Clr -> Out=0, Ovf=0.
4. Sat=1, up at Out=31 with E=1 -> Out stays 31, Sat_hit=1, O_Carry=0, Ovf=0; D=1 at 0 -> stays 0, Sat_hit=1.
5. Same edge Clr=1, Load=1 (Load_val=7), E=1 -> Out=0; then Load=1, E=1, Load_val=7 -> Out=7 (load wins); then E=0 -> Out holds 7.
6. GRAY_OUT_EN defined, WIDTH=5, up-count 0..31..0 -> Out_gray changes exactly one bit per edge, including the wrap 31->0 (10000 -> 00000).
